// File: rtl/fifo_ctrl_32_7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_32_7_pkg
// Brief    : Shared types and constants for the fifo_ctrl_32_7 slice.
//            Holds the memory control struct that goes to memory_32_7.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_ctrl_32_7_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 7;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  // Control bundle driven into the memory block's write and read ports.
  typedef struct packed {
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_address;
    logic [ADDR_W-1:0] rd_address;
  } m_32_7;

endpackage
`default_nettype wire

// File: rtl/fifo_ctrl_32_7_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_32_7_if
// Brief    : Stream and memory-port bundle of the FIFO controller.
//            slave  = the controller side, master = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_ctrl_32_7_if;
  import fifo_ctrl_32_7_pkg::*;

  // input stream
  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  // output stream
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;
  // memory ports
  m_32_7             m;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data;
  // occupancy
  logic [ADDR_W+1:0] level;

  modport slave (
    input  in_vld, in_data, out_rdy, m_rd_data,
    output in_rdy, out_vld, out_data, m, m_wr_data, level
  );

  modport master (
    output in_vld, in_data, out_rdy, m_rd_data,
    input  in_rdy, out_vld, out_data, m, m_wr_data, level
  );

endinterface
`default_nettype wire

// File: rtl/fifo_ctrl_32_7_obuf.sv
`default_nettype none
// ============================================================================
// Module   : fifo_obuf_32
// Brief    : Small circular output buffer that absorbs memory read returns.
//            head_data reads as zero while the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_obuf_32 #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic             pop_ok;

  // Index advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A pop on an empty buffer is ignored rather than corrupting the count.
  assign pop_ok    = pop && (count != '0);
  assign head_data = (count != '0) ? storage[head] : '0;

  // Pointer, count and storage update; capture and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (push) begin
        storage[tail] <= push_data;
        tail          <= next_idx(tail);
      end
      if (pop_ok) begin
        head <= next_idx(head);
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl_32_7.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_32_7
// Brief    : Streaming FIFO controller in front of the 128x32 memory_32_7.
//            Writes accepted words to memory, pre-fetches reads into a small
//            output buffer to hide the 2-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl_32_7
  import fifo_ctrl_32_7_pkg::*;
#(
  parameter int OBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  fifo_ctrl_32_7_if.slave bus
);

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int LVL_W = ADDR_W + 2;
  localparam logic [ADDR_W:0] MEM_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_count;
  logic [1:0]        inflight;        // bit0: issued last cycle, bit1: data on m_rd_data now
  logic [1:0]        inflight_count;
  logic [CNT_W-1:0]  obuf_count;
  logic [DATA_W-1:0] obuf_head;
  logic [SUM_W-1:0]  credit_used;
  logic              in_rdy;
  logic              out_vld;
  logic              push;
  logic              issue;
  logic              pop;
  logic              capture;
  m_32_7             m_out;

  // Acceptance depends only on registered occupancy, never on out_rdy.
  assign in_rdy = (mem_count != MEM_FULL);
  assign push   = bus.in_vld & in_rdy;

  // Reads are issued only while the output buffer has room for every word
  // already in flight, so a returning word always finds a free entry.
  assign inflight_count = {1'b0, inflight[0]} + {1'b0, inflight[1]};
  assign credit_used    = SUM_W'(obuf_count) + SUM_W'(inflight_count);
  assign issue          = (mem_count != '0) && (credit_used < SUM_W'(OBUF_DEPTH));
  assign capture        = inflight[1];

  assign out_vld = (obuf_count != '0);
  assign pop     = out_vld & bus.out_rdy;

  assign m_out.wr_vld     = push;
  assign m_out.wr_address = wr_ptr;
  assign m_out.rd_address = rd_ptr;

  assign bus.m         = m_out;
  assign bus.m_wr_data = bus.in_data;
  assign bus.in_rdy    = in_rdy;
  assign bus.out_vld   = out_vld;
  assign bus.out_data  = obuf_head;
  assign bus.level     = LVL_W'(mem_count) + LVL_W'(inflight_count) + LVL_W'(obuf_count);

  // Pointers, memory occupancy and the read-latency tracking shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
      inflight <= {inflight[0], issue};
    end
  end

  fifo_obuf_32 #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (DATA_W)
  ) u_obuf (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (bus.m_rd_data),
    .pop       (pop),
    .count     (obuf_count),
    .head_data (obuf_head)
  );

endmodule
`default_nettype wire

// File: doc/fifo_ctrl_32_7.md
Name: fifo_ctrl_32_7

Overview:
- Streaming FIFO controller that owns the write and read ports of the 32x128 synchronous memory block (memory_32_7).
- Converts a valid/ready input stream into memory writes, and issues memory reads to produce a valid/ready output stream.
- Hides the memory's 2-cycle read latency behind a small output buffer, so back-to-back throughput is one word per clock.
- Instantiated next to memory_32_7 in the parent; the parent wires this block's m/m_wr_data outputs to the memory and m_rd_data back.

Parameters:
- DATA_W, 32, data width; must equal the memory width.
- ADDR_W, 7, memory address width; memory depth = 2^ADDR_W = 128.
- OBUF_DEPTH, 4, output buffer entries; must be >= 3.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- in_vld  input  1  input word valid
- in_data  input  DATA_W  input word
- in_rdy  output  1  ready to accept a word
- out_vld  output  1  output word valid
- out_data  output  DATA_W  output word
- out_rdy  input  1  downstream accepts the word
- m  output  m_32_7  memory control struct: wr_vld, wr_address[ADDR_W], rd_address[ADDR_W]
- m_wr_data  output  DATA_W  memory write data
- m_rd_data  input  DATA_W  memory read data, valid 2 cycles after rd_address is presented
- level  output  ADDR_W+2  total words held: memory + in flight + output buffer

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
  - Reset clears wr_ptr, rd_ptr, mem_count, the in-flight shift register and the output buffer.
  - After reset: in_rdy=1, out_vld=0, out_data=0, level=0, m.wr_vld=0.
  - Reset mid-operation discards all held words, including reads in flight. m_rd_data returning after reset is ignored.
- Push:
  - push = in_vld & in_rdy.
  - in_rdy = (mem_count != 2^ADDR_W), computed from registered state only.
  - On push: m.wr_vld=1, m.wr_address=wr_ptr, m_wr_data=in_data (combinational from the inputs). wr_ptr increments mod 128.
- Read issue:
  - issue = (mem_count != 0) & (obuf_count + inflight_count < OBUF_DEPTH).
  - m.rd_address = rd_ptr every cycle; it is only meaningful when issue=1.
  - On issue: rd_ptr increments mod 128, and a 1 is shifted into the 2-stage inflight register.
- Counter update: mem_count increments on push and decrements on issue. On simultaneous push and issue it is unchanged.
- Write/read ordering:
  - A read is issued only for entries counted in mem_count at the start of the cycle. There is no same-cycle bypass; the first read of a word written in cycle N issues in cycle N+1 at the earliest.
  - A slot freed by issue in cycle N may be rewritten from cycle N+1. The memory reads the old value on that same edge, so no hazard exists.
- Return path:
  - When inflight stage 2 is set, m_rd_data is written into the output buffer (a circular buffer of OBUF_DEPTH entries) at the end of that cycle.
  - The issue credit rule guarantees the buffer never overflows.
- Output:
  - out_vld = (obuf_count != 0); out_data is the buffer head, or 0 when the buffer is empty.
  - pop = out_vld & out_rdy. Capture and pop in the same cycle are legal.
- Latency:
  - Push in cycle 0 into an empty FIFO with out_rdy=1 gives: issue in cycle 1, capture at the end of cycle 3, out_vld=1 in cycle 4.
  - Steady state with in_vld=out_rdy=1 is one word per cycle.
- Capacity: 128 + OBUF_DEPTH = 132 words. level = mem_count + inflight_count + obuf_count, range 0..132.
- Ordering: strict FIFO; no data is lost or duplicated under any in_vld/out_rdy pattern.

Decomposition:
- types package: m_32_7 struct (wr_vld, wr_address, rd_address) and the constants DATA_W=32, ADDR_W=7.
- One natural sub-module: fifo_obuf_32 (OBUF_DEPTH-entry circular output buffer with count, push, pop).
- Pointers, mem_count, inflight shift register and issue logic stay in the top level.

Test Plan:
- Single word: reset, then push 0xDEADBEEF in cycle 0 with out_rdy=1 -> out_vld first high in cycle 4 with out_data=0xDEADBEEF; level returns to 0.
- Fill: out_rdy=0, push 140 incrementing words 0..139 -> exactly 132 accepted, in_rdy=0 after the 132nd, level=132. Then out_rdy=1 -> outputs 0..131 in order.
- Streaming: in_vld=out_rdy=1 for 1000 cycles -> one output per cycle after startup, in order.
  - This also covers pointer wrap past address 127 -> 0 with no corruption.
- Backpressure: random in_vld and random out_rdy (50%) for 10000 words -> scoreboard exact match, level always <= 132, output buffer never overflows.
- Reset mid-operation: 50 words held with 2 reads in flight, assert reset for 1 cycle -> next cycle out_vld=0, level=0, in_rdy=1. The next pushed word 0x5 is the next output.
- Simultaneous events: mem_count=1 with push and issue in the same cycle -> mem_count stays 1. The pushed word is read on a later issue, and the words come out in order.
